// File: rtl/div_recon_mul.sv
// div_recon_mul: sequential signed shift-add multiplier that rebuilds the dividend
// from divider results: result = quotient * divisor (+ remainder when mode=1).
// Radix-2, one divisor bit per cycle; runs on magnitudes and applies the sign at the end.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high
//   quotient      signed multiplicand (Q_W)
//   divisor       signed multiplier (D_W)
//   remainder     signed addend (D_W), used only when mode=1
//   mode          1: quotient*divisor+remainder, 0: quotient*divisor
//   valid_input   operands valid; sampled only while idle
//   busy          high while an operation is in flight
//   valid_output  one-cycle pulse, result/overflow valid
//   result        low P_W bits of the exact signed sum
//   overflow      exact sum not representable in P_W signed bits
module div_recon_mul #(
  parameter int unsigned Q_W = 17,
  parameter int unsigned D_W = 16,
  parameter int unsigned P_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [Q_W-1:0] quotient,
  input  logic signed [D_W-1:0] divisor,
  input  logic signed [D_W-1:0] remainder,
  input  logic                  mode,
  input  logic                  valid_input,
  output logic                  busy,
  output logic                  valid_output,
  output logic        [P_W-1:0] result,
  output logic                  overflow
);

  localparam int unsigned MW = Q_W + D_W;  // magnitude product width
  localparam int unsigned SW = P_W + 2;    // signed sum width, wide enough for +2^31
  localparam int unsigned CW = $clog2(D_W);

  typedef enum logic [1:0] {StIdle, StMult, StFix} state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   mcand_q, mcand_d;
  logic [D_W-1:0]  mplier_q, mplier_d;
  logic [MW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [D_W-1:0]  rem_q, rem_d;
  logic            mode_q, mode_d;
  logic            valid_q, valid_d;
  logic [P_W-1:0]  result_q, result_d;
  logic            ovf_q, ovf_d;

  // Magnitudes; the most negative value maps onto its unsigned magnitude (e.g. -2^16 -> 65536).
  logic [Q_W-1:0] abs_q;
  logic [D_W-1:0] abs_d;
  assign abs_q = quotient[Q_W-1] ? $unsigned(-quotient) : $unsigned(quotient);
  assign abs_d = divisor[D_W-1]  ? $unsigned(-divisor)  : $unsigned(divisor);

  // Final signed sum; negating a zero magnitude yields zero, so no negative zero arises.
  logic signed [SW-1:0] prod_s, rem_s, sum_s;
  assign prod_s = neg_q ? -$signed(SW'(acc_q)) : $signed(SW'(acc_q));
  assign rem_s  = mode_q ? $signed({{(SW-D_W){rem_q[D_W-1]}}, rem_q}) : '0;
  assign sum_s  = prod_s + rem_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    valid_d  = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (valid_input) begin
          mcand_d  = MW'(abs_q);
          mplier_d = abs_d;
          neg_d    = quotient[Q_W-1] ^ divisor[D_W-1];
          rem_d    = remainder;
          mode_d   = mode;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StMult;
        end
      end
      StMult: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(D_W - 1)) state_d = StFix;
      end
      StFix: begin
        result_d = sum_s[P_W-1:0];
        // Representable only if the bits above the P_W sign bit all match it.
        ovf_d    = (sum_s[SW-1:P_W-1] != '0) && (sum_s[SW-1:P_W-1] != '1);
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy         = (state_q != StIdle);
  assign valid_output = valid_q;
  assign result       = result_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_div_recon_mul.sv
module tb_div_recon_mul;

  logic               clk;
  logic               reset;
  logic signed [16:0] quotient;
  logic signed [15:0] divisor;
  logic signed [15:0] remainder;
  logic               mode;
  logic               valid_input;
  logic               busy;
  logic               valid_output;
  logic        [31:0] result;
  logic               overflow;

  div_recon_mul dut (
    .clk          (clk),
    .reset        (reset),
    .quotient     (quotient),
    .divisor      (divisor),
    .remainder    (remainder),
    .mode         (mode),
    .valid_input  (valid_input),
    .busy         (busy),
    .valid_output (valid_output),
    .result       (result),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam longint PMAX = 64'sd2147483647;
  localparam longint PMIN = -64'sd2147483648;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an operation (valid_input held until the caller's accept edge) and queue its model.
  task automatic issue(input int q, input int d, input int r, input bit m);
    longint e;
    exp_t   x;
    quotient    = q[16:0];
    divisor     = d[15:0];
    remainder   = r[15:0];
    mode        = m;
    valid_input = 1'b1;
    e = longint'(q) * longint'(d) + (m ? longint'(r) : 64'sd0);
    x.res = e[31:0];
    x.ovf = (e > PMAX) || (e < PMIN);
    sb.push_back(x);
  endtask

  // Called #1 after an edge that is lat0 edges past the accept edge; waits for the pulse.
  task automatic wait_result(input string tag, input int lat0);
    int   lat;
    bit   got;
    exp_t x;
    lat = lat0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (valid_output) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check({tag, " done"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, " latency"}, 64'(lat), 64'd17);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " sb"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check({tag, " result"}, 64'(result), 64'(x.res));
        check({tag, " overflow"}, 64'(overflow), 64'(x.ovf));
      end
    end
  endtask

  // Accept edge for an already-issued op, then collect its result.
  task automatic run_and_check(input string tag);
    @(posedge clk);
    #1;
    valid_input = 1'b0;
    check({tag, " busy_acc"}, 64'(busy), 64'd1);
    wait_result(tag, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int tq[8] = '{26, 26, -26, -26, 26, 26, -26, -26};
  int td[8] = '{3, -3, 3, -3, 3, -3, 3, -3};
  int tr[8] = '{2, -2, -2, 2, 2, -2, -2, 2};
  bit tm[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int npulse;
  exp_t dummy;

  initial begin
    reset       = 1'b1;
    quotient    = '0;
    divisor     = '0;
    remainder   = '0;
    mode        = 1'b0;
    valid_input = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", 64'(result), 64'd0);
    check("reset ovf", 64'(overflow), 64'd0);
    check("reset valid", 64'(valid_output), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic reconstruction
    issue(26, 3, 2, 1'b1);
    run_and_check("t1");
    check("t1 const", 64'(result), 64'd80);

    // 2: sign combinations, both modes
    for (int i = 0; i < 8; i++) begin
      issue(tq[i], td[i], tr[i], tm[i]);
      run_and_check($sformatf("t2_%0d", i));
    end

    // 3: zero operands and extremes
    issue(1234, 0, -7, 1'b1);
    run_and_check("t3_dzero");
    issue(0, -32768, 5, 1'b0);
    run_and_check("t3_qzero");
    issue(-65536, -32768, 0, 1'b0);
    run_and_check("t3_max");
    check("t3_max res", 64'(result), 64'h8000_0000);
    check("t3_max ovf", 64'(overflow), 64'd1);
    issue(-65536, 32767, 0, 1'b0);
    run_and_check("t3_min");
    check("t3_min ovf", 64'(overflow), 64'd0);

    // 4: valid_input while busy is ignored; back-to-back in the pulse cycle is accepted
    issue(1000, 100, 7, 1'b1);
    @(posedge clk);                          // edge k
    #1 valid_input = 1'b0;
    repeat (2) @(posedge clk);
    #1 valid_input = 1'b1;
    quotient = 17'sd5;
    @(posedge clk);                          // edge k+3
    #1 valid_input = 1'b0;
    repeat (6) @(posedge clk);
    #1 valid_input = 1'b1;
    @(posedge clk);                          // edge k+10
    #1 valid_input = 1'b0;
    wait_result("t4_first", 10);
    issue(-300, 211, -9, 1'b1);
    run_and_check("t4_second");
    npulse = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (valid_output) npulse++;
    end
    check("t4 no extra", 64'(npulse), 64'd0);

    // 5: reset mid-MULT discards the op
    issue(77, 88, 1, 1'b1);
    @(posedge clk);                          // edge k
    #1 valid_input = 1'b0;
    repeat (7) @(posedge clk);
    @(posedge clk);                          // edge k+8
    reset = 1'b1;
    #1;
    check("t5 rst result", 64'(result), 64'd0);
    check("t5 rst busy", 64'(busy), 64'd0);
    check("t5 rst valid", 64'(valid_output), 64'd0);
    dummy = sb.pop_front();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_output) npulse++;
    end
    check("t5 no pulse", 64'(npulse), 64'd0);
    issue(-123, 456, -78, 1'b1);
    run_and_check("t5_after");

    // 6: random back-to-back
    for (int i = 0; i < 1000; i++) begin
      int q, d, r;
      q = int'($urandom_range(0, 131071)) - 65536;
      d = int'($urandom_range(0, 65535)) - 32768;
      r = int'($urandom_range(0, 65535)) - 32768;
      if (i % 50 == 0) q = -65536;
      if (i % 70 == 0) d = -32768;
      issue(q, d, r, 1'($urandom_range(0, 1)));
      run_and_check("t6");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
